uart_tx_fifo: RTL and testbench

UART transmitter that drains the SoC's byte FIFO from its reader side and serializes each entry as an 8N1-style asynchronous frame on `tx_o`. It sits between the TX FIFO (written by the CPU bus) and the UART pin. It owns the FIFO reader handshake: it pops one entry per frame and sends frames back-to-back while data is available.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Rounded clock-cycles-per-bit for a given clock and baud rate.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + (baud / 32'sd2)) / baud;
  endfunction

  localparam int DEFAULT_CLKS_PER_BIT = clks_per_bit(32'sd50_000_000, 32'sd115_200);

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pops bytes from a FIFO reader port and sends them as
// back-to-back start/data/stop frames on tx_o.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_deq_o,
  input  logic                  enable_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int STOP_W = $clog2(STOP_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_ONE  = STOP_W'(1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [STOP_W-1:0]     stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  deq_s;
  logic                  start_s;

  assign start_s = enable_i && !fifo_empty_i;

  // Frame sequencer: state, counters and shift register next-state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    deq_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          deq_s   = 1'b1;
          shift_d = fifo_q_i;
          baud_d  = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            stop_d  = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            stop_d = '0;
            // Chaining straight into the next start bit keeps frames gap-free.
            if (start_s) begin
              deq_s   = 1'b1;
              shift_d = fifo_q_i;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + STOP_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output lookahead so tx/busy/done come straight from flops.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (stop_d == STOP_LAST);
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_deq_o = deq_s && !reset_i;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) each fed by a small
// FIFO model; a frame decoder checks every transmitted byte against a scoreboard.
module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, en, deq_w, empty_w, tx_w, busy_w, done_w;
  logic [1:0][7:0] q_w;
  logic [7:0]      mem [2][16];
  logic [1:0][4:0] rd_ptr, wr_ptr;
  logic            fifo_clr;
  logic [7:0]      sb0[$];
  logic [7:0]      sb1[$];
  int              checks = 0;
  int              errors = 0;
  logic            tx_tr [200];
  logic            busy_tr [200];
  logic            done_tr [200];
  logic            deq_tr [200];

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset_i(rst[0]), .fifo_q_i(q_w[0]), .fifo_empty_i(empty_w[0]),
    .fifo_deq_o(deq_w[0]), .enable_i(en[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_i(rst[1]), .fifo_q_i(q_w[1]), .fifo_empty_i(empty_w[1]),
    .fifo_deq_o(deq_w[1]), .enable_i(en[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]));

  // FIFO models: head is always valid while non-empty.
  assign q_w[0]     = mem[0][rd_ptr[0][3:0]];
  assign q_w[1]     = mem[1][rd_ptr[1][3:0]];
  assign empty_w[0] = (rd_ptr[0] == wr_ptr[0]);
  assign empty_w[1] = (rd_ptr[1] == wr_ptr[1]);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= '0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (deq_w[u] && !empty_w[u]) rd_ptr[u] <= rd_ptr[u] + 5'd1;
      end
    end
  end

  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    else if (k <= DW) return d[k-1];
    else return 1'b1;
  endfunction

  task automatic enq(input int u, input logic [7:0] d);
    mem[u][wr_ptr[u][3:0]] = d;
    wr_ptr[u] = wr_ptr[u] + 5'd1;
    if (u == 0) sb0.push_back(d);
    else sb1.push_back(d);
  endtask

  // Decodes each frame after a dequeue and compares it with the scoreboard.
  task automatic monitor(input int u, input int nstop);
    logic [7:0] exp_b, got;
    logic       aborted, framing_ok;
    int         sz, k;
    forever begin
      @(negedge clk);
      if (deq_w[u] === 1'b1) begin
        checks++;
        if (empty_w[u] !== 1'b0) begin
          errors++;
          $display("FAIL deq_when_empty unit %0d: empty=%b required 0", u, empty_w[u]);
        end
        sz = (u == 0) ? sb0.size() : sb1.size();
        exp_b = 8'h00;
        if (sz > 0) begin
          if (u == 0) exp_b = sb0.pop_front();
          else exp_b = sb1.pop_front();
        end else begin
          errors++;
          $display("FAIL unexpected_deq unit %0d: dequeue with nothing queued", u);
        end
        aborted = 1'b0; framing_ok = 1'b1; got = 8'h00;
        for (int j = 1; j <= (DW + nstop) * C + 2; j++) begin
          @(negedge clk);
          if (rst[u]) begin
            aborted = 1'b1;
            break;
          end
          if (j >= 2 && ((j - 2) % C) == 0) begin
            k = (j - 2) / C;
            if (k == 0) framing_ok = framing_ok & (tx_w[u] == 1'b0);
            else if (k <= DW) got[k-1] = tx_w[u];
            else framing_ok = framing_ok & (tx_w[u] == 1'b1);
          end
        end
        if (!aborted && sz > 0) begin
          checks++;
          if (got !== exp_b || !framing_ok) begin
            errors++;
            $display("FAIL frame_data unit %0d: got %h framing_ok=%b required %h framing_ok=1",
                     u, got, framing_ok, exp_b);
          end
        end
      end
    end
  endtask

  initial monitor(0, 1);
  initial monitor(1, 2);

  task automatic wait_deq(input int u);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (deq_w[u] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL deq_timeout unit %0d: no dequeue within 200 cycles, required one", u);
    end
  endtask

  task automatic capture(input int u, input int n);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      tx_tr[j] = tx_w[u]; busy_tr[j] = busy_w[u];
      done_tr[j] = done_w[u]; deq_tr[j] = deq_w[u];
    end
  endtask

  task automatic test_reset();
    int bad;
    en = 2'b11;
    @(posedge clk); #1 rst = 2'b00;
    @(negedge clk);
    checks++;
    if ({tx_w, busy_w, done_w, deq_w} !== 8'b11_00_00_00) begin
      errors++;
      $display("FAIL reset_state: tx,busy,done,deq=%b required 11000000",
               {tx_w, busy_w, done_w, deq_w});
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_w !== 2'b11 || busy_w !== 2'b00 || deq_w !== 2'b00 || done_w !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_empty: %0d bad idle cycles, required 0", bad);
    end
  endtask

  task automatic test_single();
    int bad_tx, bad_busy, n_done, done_at, n_deq;
    @(posedge clk); #1 enq(0, 8'hA5);
    wait_deq(0);
    capture(0, 48);
    bad_tx = 0; bad_busy = 0; n_done = 0; done_at = -1; n_deq = 0;
    for (int j = 1; j <= 48; j++) begin
      if (tx_tr[j] !== ((j <= 40) ? fbit(8'hA5, (j - 1) / C) : 1'b1)) bad_tx++;
      if (busy_tr[j] !== (j <= 40)) bad_busy++;
      if (done_tr[j] === 1'b1) begin n_done++; done_at = j; end
      if (deq_tr[j] === 1'b1) n_deq++;
    end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL single_tx_bits: %0d wrong cycles, required 0", bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL single_busy: %0d wrong cycles, required 0", bad_busy); end
    checks++;
    if (n_done != 1 || done_at != 40) begin
      errors++; $display("FAIL single_done: %0d pulses last at %0d, required 1 at 40", n_done, done_at);
    end
    checks++;
    if (n_deq != 0) begin errors++; $display("FAIL single_extra_deq: %0d, required 0", n_deq); end
    checks++;
    if (empty_w[0] !== 1'b1) begin errors++; $display("FAIL single_fifo_empty: %b required 1", empty_w[0]); end
  endtask

  task automatic test_back_to_back(input int u, input int nstop);
    int len, bad_tx, bad_busy, n_done, n_deq, f;
    logic [7:0] d;
    len = (1 + DW + nstop) * C;
    @(posedge clk); #1 enq(u, 8'h00); enq(u, 8'hFF);
    wait_deq(u);
    capture(u, 2 * len + 8);
    bad_tx = 0; bad_busy = 0; n_done = 0; n_deq = 0;
    for (int j = 1; j <= 2 * len + 8; j++) begin
      f = (j - 1) / len;
      d = (f == 0) ? 8'h00 : 8'hFF;
      if (tx_tr[j] !== ((j <= 2 * len) ? fbit(d, ((j - 1) % len) / C) : 1'b1)) bad_tx++;
      if (busy_tr[j] !== (j <= 2 * len)) bad_busy++;
      if (done_tr[j] === 1'b1) n_done++;
      if (deq_tr[j] === 1'b1) n_deq++;
    end
    checks++;
    if (bad_tx != 0) begin errors++; $display("FAIL b2b_tx_bits u%0d: %0d wrong cycles, required 0", u, bad_tx); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL b2b_busy u%0d: %0d wrong cycles, required 0", u, bad_busy); end
    checks++;
    if (n_done != 2 || done_tr[len] !== 1'b1 || done_tr[2 * len] !== 1'b1) begin
      errors++; $display("FAIL b2b_done u%0d: %0d pulses, required 2 at %0d and %0d", u, n_done, len, 2 * len);
    end
    checks++;
    if (n_deq != 1 || deq_tr[len] !== 1'b1) begin
      errors++; $display("FAIL b2b_deq u%0d: %0d dequeues, required 1 at cycle %0d", u, n_deq, len);
    end
    checks++;
    if (tx_tr[len] !== 1'b1 || tx_tr[len + 1] !== 1'b0) begin
      errors++; $display("FAIL b2b_gap u%0d: tx %b%b around frame edge, required 10", u, tx_tr[len], tx_tr[len + 1]);
    end
    checks++;
    if (nstop == 2 && (tx_tr[len - 8] !== 1'b0 || tx_tr[len - 7] !== 1'b1)) begin
      errors++; $display("FAIL stop2_length u%0d: tx %b%b at stop start, required 01", u, tx_tr[len - 8], tx_tr[len - 7]);
    end
  endtask

  task automatic test_mid_frame_reset();
    int n_done, done_at, n_deq;
    @(posedge clk); #1 enq(0, 8'h3C); enq(0, 8'h5A);
    wait_deq(0);
    repeat (14) @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b100) begin
      errors++; $display("FAIL reset_abort: tx,busy,done=%b required 100", {tx_w[0], busy_w[0], done_w[0]});
    end
    checks++;
    if (deq_w[0] !== 1'b1) begin
      errors++; $display("FAIL post_reset_deq: deq=%b required 1", deq_w[0]);
    end
    capture(0, 48);
    n_done = 0; done_at = -1; n_deq = 0;
    for (int j = 1; j <= 48; j++) begin
      if (done_tr[j] === 1'b1) begin n_done++; done_at = j; end
      if (deq_tr[j] === 1'b1) n_deq++;
    end
    checks++;
    if (n_done != 1 || done_at != 40) begin
      errors++; $display("FAIL post_reset_done: %0d pulses last at %0d, required 1 at 40", n_done, done_at);
    end
    checks++;
    if (n_deq != 0 || sb0.size() != 0) begin
      errors++; $display("FAIL no_retransmit: %0d extra deq, %0d pending, required 0 and 0", n_deq, sb0.size());
    end
  endtask

  task automatic test_enable();
    int n_deq, n_done;
    @(posedge clk); #1 en[0] = 1'b0;
    enq(0, 8'h11); enq(0, 8'h22); enq(0, 8'h33);
    n_deq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (deq_w[0] === 1'b1) n_deq++;
    end
    checks++;
    if (n_deq != 0) begin errors++; $display("FAIL disabled_deq: %0d, required 0", n_deq); end
    @(posedge clk); #1 en[0] = 1'b1;
    wait_deq(0);
    repeat (10) @(posedge clk);
    #1 en[0] = 1'b0;
    capture(0, 60);
    n_deq = 0; n_done = 0;
    for (int j = 1; j <= 60; j++) begin
      if (deq_tr[j] === 1'b1) n_deq++;
      if (done_tr[j] === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 1 || done_tr[31] !== 1'b1) begin
      errors++; $display("FAIL pause_frame_done: %0d pulses, required 1 at 31", n_done);
    end
    checks++;
    if (n_deq != 0) begin errors++; $display("FAIL pause_deq: %0d, required 0", n_deq); end
    checks++;
    if (wr_ptr[0] - rd_ptr[0] != 5'd2) begin
      errors++; $display("FAIL pause_remaining: %0d entries, required 2", wr_ptr[0] - rd_ptr[0]);
    end
    @(posedge clk); #1 en[0] = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (empty_w[0] !== 1'b1 || sb0.size() != 0) begin
      errors++; $display("FAIL resume_drain: empty=%b pending=%0d, required 1 and 0", empty_w[0], sb0.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 2'b11; en = 2'b00; fifo_clr = 1'b1; wr_ptr = '0;
    repeat (3) @(posedge clk);
    #1 fifo_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back(0, 1);
    test_mid_frame_reset();
    test_enable();
    test_back_to_back(1, 2);
    repeat (20) @(negedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
